// File: rtl/scroll_pkg.sv
// Shared constants, state encoding and code-stepping helper for the
// rotating-message sequencer.
package scroll_pkg;

  localparam int C_W             = 3;
  localparam int NUM_POS_DEFAULT = 6;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Wraps within 0..num_pos-1 in either direction; dn=1 steps downwards.
  function automatic logic [C_W-1:0] next_code(input logic [C_W-1:0] c,
                                               input logic           dn,
                                               input int             num_pos);
    logic [C_W-1:0] last;
    last = C_W'(num_pos - 1);
    if (dn) begin
      return (c == '0) ? last : c - C_W'(1);
    end
    return (c == last) ? '0 : c + C_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop that
// turns the synchronised level into a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign level = s2_reg;
  assign rise  = s2_reg & ~s3_reg;

endmodule

// File: rtl/scroll_ctrl.sv
// Rotation-code sequencer: auto-advances once per display period in RUN,
// single-steps from a pushbutton in HOLD.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int NUM_POS = NUM_POS_DEFAULT
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           run,
  input  logic           dir,
  input  logic           step,
  output logic [C_W-1:0] C,
  output logic           tick,
  output logic           state_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic           run_s;
  logic           unused_run_rise;
  logic           step_e;
  logic           unused_step_level;

  state_t         state_reg, state_next;
  logic [PW-1:0]  presc_reg, presc_next;
  logic [C_W-1:0] c_reg, c_next;
  logic           tick_reg, tick_next;
  logic           advance;
  logic           presc_wrap;

  sync_edge u_sync_run (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (run),
    .level (run_s),
    .rise  (unused_run_rise)
  );

  sync_edge u_sync_step (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (step),
    .level (unused_step_level),
    .rise  (step_e)
  );

  assign presc_wrap = (presc_reg == PW'(DIV - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= ST_HOLD;
      presc_reg <= '0;
      c_reg     <= '0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      c_reg     <= c_next;
      tick_reg  <= tick_next;
    end
  end

  // The advance is decided from the current state, so a step arriving on the
  // edge that enters RUN, or a wrap on the edge that leaves RUN, still lands.
  always_comb begin
    state_next = state_reg;
    presc_next = '0;
    advance    = 1'b0;

    case (state_reg)
      ST_HOLD: begin
        advance = step_e;
        if (run_s) state_next = ST_RUN;
      end
      ST_RUN: begin
        advance = presc_wrap;
        if (run_s) begin
          presc_next = presc_wrap ? '0 : presc_reg + PW'(1);
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_HOLD;
    endcase

    c_next    = advance ? next_code(c_reg, dir, NUM_POS) : c_reg;
    tick_next = advance;
  end

  assign C       = c_reg;
  assign tick    = tick_reg;
  assign state_o = (state_reg == ST_RUN);

endmodule
